chirp_sample_packetizer: RTL and testbench

- Upstream of the AXI-Stream chirp buffer stage; drives that stage's S_AXIS_* slave inputs.
- Captures exactly SAMPLES_PER_CHIRP ADC words per chirp, starting on a chirp_start pulse.
- Stores the words in a small FIFO and emits them as one AXI-Stream packet per chirp, with tlast on the final beat.
- Counts dropped samples and completed chirps for debug.

---
 rtl/chirp_sample_packetizer.sv | 146 ++++++++++++++
 tb/tb_chirp_sample_packetizer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_sample_packetizer.sv
// Captures SAMPLES_PER_CHIRP ADC words per chirp into a small FWFT FIFO and streams them as one AXI-Stream packet.
// Optional build macro PACKETIZER_TEST_PATTERN_EN replaces the payload with {chirp_cnt, sample_index}.
module chirp_sample_packetizer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLES_PER_CHIRP    = 256,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                                m_axis_aclk,
    input  logic                                m_axis_aresetn,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     adc_data,
    input  logic                                adc_valid,
    input  logic                                chirp_start,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_tstrb,
    output logic                                M_AXIS_tlast,
    output logic                                M_AXIS_tvalid,
    input  logic                                M_AXIS_tready,
    output logic [15:0]                         overflow_cnt,
    output logic [15:0]                         chirp_cnt,
    output logic                                busy
);
    localparam int DW    = C_M_AXIS_TDATA_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0]      LAST_IDX = 16'(SAMPLES_PER_CHIRP - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_MAX : p - PTR_W'(1);
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       idx_q, idx_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       ovf_q, chirp_q;

    logic [DW-1:0]         mem_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;

    logic          capture_vld, is_last, full, push, pop, drop, drop_last, head_last;
    logic [DW-1:0] payload;

    assign capture_vld = (state_q == CAPTURE) && adc_valid;
    assign is_last     = (idx_q == LAST_IDX);
    assign full        = (count_q == FULL_CNT);
    assign pop         = M_AXIS_tvalid && M_AXIS_tready;
    assign push        = capture_vld && (!full || pop);
    assign drop        = capture_vld && !push;
    assign drop_last   = drop && is_last;
    assign head_last   = mem_last_q[rd_ptr_q];

`ifdef PACKETIZER_TEST_PATTERN_EN
    logic [31:0] pattern;
    logic        unused_adc;
    assign pattern    = {chirp_q, idx_q};
    assign unused_adc = ^adc_data;
    always_comb begin
        payload = '0;
        for (int i = 0; i < DW && i < 32; i++) payload[i] = pattern[i];
    end
`else
    assign payload = adc_data;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (chirp_start) begin
                    state_d = CAPTURE;
                    idx_d   = '0;
                end
            end
            CAPTURE: begin
                // Dropped samples still advance the index so the chirp length is fixed.
                if (adc_valid) begin
                    idx_d = idx_q + 16'd1;
                    if (is_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (!m_axis_aresetn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            chirp_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (drop) ovf_q    <= sat_inc16(ovf_q);
            if (pop && head_last) chirp_q <= chirp_q + 16'd1;
        end
    end

    // Storage is not reset; an empty FIFO masks it at the outputs.
    always_ff @(posedge m_axis_aclk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= payload;
            mem_last_q[wr_ptr_q] <= is_last;
        end
        if (drop_last) mem_last_q[ptr_dec(wr_ptr_q)] <= 1'b1;
    end

    assign M_AXIS_tvalid = (count_q != '0);
    assign M_AXIS_tdata  = M_AXIS_tvalid ? mem_data_q[rd_ptr_q] : '0;
    assign M_AXIS_tlast  = M_AXIS_tvalid && head_last;
    assign M_AXIS_tstrb  = '1;
    assign overflow_cnt  = ovf_q;
    assign chirp_cnt     = chirp_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_chirp_sample_packetizer.sv
// Directed bench: instance A (8 samples/chirp) and instance B (20 samples/chirp), both with a 16-entry FIFO.
module tb_chirp_sample_packetizer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aresetn;

    logic [31:0] a_adc_data, a_tdata;
    logic        a_adc_valid, a_chirp_start, a_tready, a_tlast, a_tvalid, a_busy;
    logic [3:0]  a_tstrb;
    logic [15:0] a_ovf, a_chirps;

    logic [31:0] b_adc_data, b_tdata;
    logic        b_adc_valid, b_chirp_start, b_tready, b_tlast, b_tvalid, b_busy;
    logic [3:0]  b_tstrb;
    logic [15:0] b_ovf, b_chirps;

    int total = 0;
    int bad   = 0;

`ifdef PACKETIZER_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    chirp_sample_packetizer #(.C_M_AXIS_TDATA_WIDTH(32), .SAMPLES_PER_CHIRP(8), .FIFO_DEPTH(16)) dut_a (
        .m_axis_aclk(clk), .m_axis_aresetn(aresetn),
        .adc_data(a_adc_data), .adc_valid(a_adc_valid), .chirp_start(a_chirp_start),
        .M_AXIS_tdata(a_tdata), .M_AXIS_tstrb(a_tstrb), .M_AXIS_tlast(a_tlast),
        .M_AXIS_tvalid(a_tvalid), .M_AXIS_tready(a_tready),
        .overflow_cnt(a_ovf), .chirp_cnt(a_chirps), .busy(a_busy)
    );

    chirp_sample_packetizer #(.C_M_AXIS_TDATA_WIDTH(32), .SAMPLES_PER_CHIRP(20), .FIFO_DEPTH(16)) dut_b (
        .m_axis_aclk(clk), .m_axis_aresetn(aresetn),
        .adc_data(b_adc_data), .adc_valid(b_adc_valid), .chirp_start(b_chirp_start),
        .M_AXIS_tdata(b_tdata), .M_AXIS_tstrb(b_tstrb), .M_AXIS_tlast(b_tlast),
        .M_AXIS_tvalid(b_tvalid), .M_AXIS_tready(b_tready),
        .overflow_cnt(b_ovf), .chirp_cnt(b_chirps), .busy(b_busy)
    );

    function automatic logic [31:0] exp_payload(input int chirp, input int idx, input logic [31:0] adc);
        return TP ? {chirp[15:0], idx[15:0]} : adc;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        tick();
        tick();
        total++; if (a_tvalid !== 1'b0) begin bad++; $display("FAIL reset_a_tvalid got=%0b want=0", a_tvalid); end
        total++; if (a_tlast !== 1'b0) begin bad++; $display("FAIL reset_a_tlast got=%0b want=0", a_tlast); end
        total++; if (a_tdata !== 32'h0) begin bad++; $display("FAIL reset_a_tdata got=%h want=0", a_tdata); end
        total++; if (a_tstrb !== 4'hF) begin bad++; $display("FAIL reset_a_tstrb got=%h want=f", a_tstrb); end
        total++; if (a_ovf !== 16'h0 || a_chirps !== 16'h0) begin bad++; $display("FAIL reset_a_counters got=%h/%h want=0/0", a_ovf, a_chirps); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_a_busy got=%0b want=0", a_busy); end
        total++; if (b_tvalid !== 1'b0 || b_busy !== 1'b0) begin bad++; $display("FAIL reset_b_idle got=%0b/%0b want=0/0", b_tvalid, b_busy); end
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_basic_packet;
        a_tready = 1'b1;
        a_chirp_start = 1'b1;
        tick();
        a_chirp_start = 1'b0;
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", a_busy); end
        for (int i = 0; i < 8; i++) begin
            a_adc_valid = 1'b1;
            a_adc_data  = 32'h100 + i;
            tick();
            total++;
            if (a_tvalid !== 1'b1 || a_tdata !== exp_payload(0, i, 32'h100 + i) || a_tlast !== (i == 7)) begin
                bad++;
                $display("FAIL basic_beat%0d got=%0b/%h/%0b want=1/%h/%0b", i, a_tvalid, a_tdata, a_tlast,
                         exp_payload(0, i, 32'h100 + i), (i == 7));
            end
        end
        a_adc_valid = 1'b0;
        tick();
        total++; if (a_tvalid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%0b want=0", a_tvalid); end
        total++; if (a_chirps !== 16'd1) begin bad++; $display("FAIL basic_chirp_cnt got=%0d want=1", a_chirps); end
        tick();
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0b want=0", a_busy); end
        total++; if (a_ovf !== 16'd0) begin bad++; $display("FAIL basic_ovf got=%0d want=0", a_ovf); end
    endtask

    task automatic test_stray_start;
        int n;
        a_tready = 1'b0;
        a_chirp_start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            a_adc_valid   = 1'b1;
            a_adc_data    = 32'h200 + i;
            a_chirp_start = (i == 3);
            tick();
        end
        a_adc_valid   = 1'b0;
        a_chirp_start = 1'b1;
        tick();
        a_chirp_start = 1'b0;
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL stray_drain_busy got=%0b want=1", a_busy); end
        a_tready = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (a_tvalid === 1'b1) begin
                total++;
                if (n >= 8) begin
                    bad++;
                    $display("FAIL stray_extra_beat got=%h want=no_beat", a_tdata);
                end else if (a_tdata !== exp_payload(1, n, 32'h200 + n) || a_tlast !== (n == 7)) begin
                    bad++;
                    $display("FAIL stray_beat%0d got=%h/%0b want=%h/%0b", n, a_tdata, a_tlast,
                             exp_payload(1, n, 32'h200 + n), (n == 7));
                end
                n++;
            end
            tick();
        end
        total++; if (n != 8) begin bad++; $display("FAIL stray_beat_count got=%0d want=8", n); end
        total++; if (a_chirps !== 16'd2) begin bad++; $display("FAIL stray_chirp_cnt got=%0d want=2", a_chirps); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL stray_idle got=%0b want=0", a_busy); end
        a_adc_valid = 1'b1;
        tick();
        tick();
        tick();
        a_adc_valid = 1'b0;
        total++; if (a_tvalid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL idle_ignores_adc got=%0b/%0b want=0/0", a_tvalid, a_busy); end
    endtask

    task automatic test_overflow;
        int n;
        b_tready = 1'b0;
        b_chirp_start = 1'b1;
        tick();
        b_chirp_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b_adc_valid = 1'b1;
            b_adc_data  = 32'h100 + i;
            tick();
        end
        b_adc_valid = 1'b0;
        total++; if (b_ovf !== 16'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", b_ovf); end
        total++; if (b_tvalid !== 1'b1 || b_tdata !== exp_payload(0, 0, 32'h100)) begin bad++; $display("FAIL ovf_head got=%0b/%h want=1/%h", b_tvalid, b_tdata, exp_payload(0, 0, 32'h100)); end
        tick();
        total++; if (b_tdata !== exp_payload(0, 0, 32'h100) || b_busy !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%h/%0b want=%h/1", b_tdata, b_busy, exp_payload(0, 0, 32'h100)); end
        b_tready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 16; c++) begin
            if (b_tvalid === 1'b1) begin
                total++;
                if (b_tdata !== exp_payload(0, n, 32'h100 + n) || b_tlast !== (n == 15)) begin
                    bad++;
                    $display("FAIL ovf_beat%0d got=%h/%0b want=%h/%0b", n, b_tdata, b_tlast,
                             exp_payload(0, n, 32'h100 + n), (n == 15));
                end
                n++;
            end
            tick();
        end
        total++; if (n != 16) begin bad++; $display("FAIL ovf_beat_count got=%0d want=16", n); end
        total++; if (b_chirps !== 16'd1 || b_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_end got=%0d/%0b want=1/0", b_chirps, b_tvalid); end
        tick();
        total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL ovf_idle got=%0b want=0", b_busy); end
    endtask

    task automatic test_full_with_pop;
        int n;
        b_tready = 1'b0;
        b_chirp_start = 1'b1;
        tick();
        b_chirp_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_adc_valid = 1'b1;
            b_adc_data  = 32'h100 + i;
            tick();
        end
        total++; if (b_ovf !== 16'd4 || b_tdata !== exp_payload(1, 0, 32'h100)) begin bad++; $display("FAIL fullpop_pre got=%0d/%h want=4/%h", b_ovf, b_tdata, exp_payload(1, 0, 32'h100)); end
        b_tready   = 1'b1;
        b_adc_data = 32'h110;
        tick();
        b_tready = 1'b0;
        total++; if (b_ovf !== 16'd4) begin bad++; $display("FAIL fullpop_ovf got=%0d want=4", b_ovf); end
        total++; if (b_tdata !== exp_payload(1, 1, 32'h101)) begin bad++; $display("FAIL fullpop_head got=%h want=%h", b_tdata, exp_payload(1, 1, 32'h101)); end
        for (int i = 17; i < 20; i++) begin
            b_adc_data = 32'h100 + i;
            tick();
        end
        b_adc_valid = 1'b0;
        total++; if (b_ovf !== 16'd7) begin bad++; $display("FAIL fullpop_drops got=%0d want=7", b_ovf); end
        b_tready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 16; c++) begin
            if (b_tvalid === 1'b1) begin
                total++;
                if (b_tdata !== exp_payload(1, n + 1, 32'h101 + n) || b_tlast !== (n == 15)) begin
                    bad++;
                    $display("FAIL fullpop_beat%0d got=%h/%0b want=%h/%0b", n, b_tdata, b_tlast,
                             exp_payload(1, n + 1, 32'h101 + n), (n == 15));
                end
                n++;
            end
            tick();
        end
        total++; if (n != 16) begin bad++; $display("FAIL fullpop_beat_count got=%0d want=16", n); end
        total++; if (b_chirps !== 16'd2) begin bad++; $display("FAIL fullpop_chirp_cnt got=%0d want=2", b_chirps); end
        tick();
    endtask

    task automatic test_reset_mid_frame;
        a_tready = 1'b0;
        a_chirp_start = 1'b1;
        tick();
        a_chirp_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_adc_valid = 1'b1;
            a_adc_data  = 32'h2F0 + i;
            tick();
        end
        a_adc_valid = 1'b0;
        aresetn = 1'b0;
        tick();
        total++; if (a_tvalid !== 1'b0 || a_tdata !== 32'h0 || a_tlast !== 1'b0) begin bad++; $display("FAIL midrst_outputs got=%0b/%h/%0b want=0/0/0", a_tvalid, a_tdata, a_tlast); end
        total++; if (a_chirps !== 16'd0 || a_ovf !== 16'd0 || a_busy !== 1'b0) begin bad++; $display("FAIL midrst_state got=%0d/%0d/%0b want=0/0/0", a_chirps, a_ovf, a_busy); end
        total++; if (b_chirps !== 16'd0 || b_ovf !== 16'd0) begin bad++; $display("FAIL midrst_b_counters got=%0d/%0d want=0/0", b_chirps, b_ovf); end
        aresetn  = 1'b1;
        a_tready = 1'b1;
        tick();
        tick();
        total++; if (a_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_discard got=%0b want=0", a_tvalid); end
        a_chirp_start = 1'b1;
        tick();
        a_chirp_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_adc_valid = 1'b1;
            a_adc_data  = 32'h300 + i;
            tick();
            total++;
            if (a_tvalid !== 1'b1 || a_tdata !== exp_payload(0, i, 32'h300 + i) || a_tlast !== (i == 7)) begin
                bad++;
                $display("FAIL midrst_beat%0d got=%0b/%h/%0b want=1/%h/%0b", i, a_tvalid, a_tdata, a_tlast,
                         exp_payload(0, i, 32'h300 + i), (i == 7));
            end
        end
        a_adc_valid = 1'b0;
        tick();
        total++; if (a_chirps !== 16'd1 || a_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_end got=%0d/%0b want=1/0", a_chirps, a_tvalid); end
    endtask

    initial begin
        aresetn = 1'b0;
        a_adc_data = '0; a_adc_valid = 1'b0; a_chirp_start = 1'b0; a_tready = 1'b0;
        b_adc_data = '0; b_adc_valid = 1'b0; b_chirp_start = 1'b0; b_tready = 1'b0;
        test_reset();
        test_basic_packet();
        test_stray_start();
        test_overflow();
        test_full_with_pop();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
